ysyx_trap_ctrl: RTL
===================

Name: ysyx_trap_ctrl

Overview:
- Trap sequencer that drives the EXU-side CSR write port (wen/waddr/wdata plus the add1 second write lane) of the machine-mode CSR register file.
- Trap entry (ecall, ebreak, illegal instruction): writes mepc, mcause and mstatus in order, then redirects fetch to mtvec.
- mret: restores mstatus, then redirects fetch to mepc.
- Asserts busy to stall EXU for the whole sequence.

Parameters:
- BIT_W, 32: data width (ysyx_W_WIDTH).
- R_W, 12: CSR address width.
- CAUSE_ILLEGAL, 2: mcause code for an illegal instruction.
- CAUSE_BREAK, 3: mcause code for ebreak.
- CAUSE_ECALL_M, 11: mcause code for ecall from M-mode.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- exu_valid  in  1  EXU presents a valid retiring instruction.
- ecall  in  1  the instruction is ecall.
- ebreak  in  1  the instruction is ebreak.
- illegal  in  1  the instruction is illegal.
- mret  in  1  the instruction is mret.
- pc  in  BIT_W  PC of the instruction.
- mtvec_i  in  BIT_W  current mtvec.
- mepc_i  in  BIT_W  current mepc.
- mstatus_i  in  BIT_W  current mstatus.
- csr_wen  out  1  CSR write enable.
- csr_waddr  out  R_W  write address, lane 0.
- csr_wdata  out  BIT_W  write data, lane 0.
- csr_waddr_add1  out  R_W  write address, lane 1.
- csr_wdata_add1  out  BIT_W  write data, lane 1.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  BIT_W  redirect target.
- redirect_ready  in  1  IFU accepts the redirect.
- busy  out  1  stall EXU / block new issue.

Behaviour:
- Reset: state IDLE. All outputs 0. Captured registers cleared.

FSM states: IDLE, WR_EPC, WR_STAT, REDIR.

IDLE:
- busy=0, csr_wen=0.
- Accept when exu_valid && (illegal|ebreak|ecall|mret).
- Priority: illegal > ebreak > ecall > mret.
- On accept, capture in the same edge:
  - epc = {pc[BIT_W-1:2],2'b00}.
  - cause = code of the winning trap.
  - is_mret.
  - mstatus snapshot = mstatus_i.
  - target = {mtvec_i[BIT_W-1:2],2'b00} for a trap; mepc_i for mret. mtvec is direct mode only; the low two bits are ignored.
- Next state: trap -> WR_EPC; mret -> WR_STAT.

WR_EPC (1 cycle):
- csr_wen=1.
- waddr=0x341, wdata=epc.
- waddr_add1=0x342, wdata_add1=cause.
- Next: WR_STAT.

WR_STAT (1 cycle):
- csr_wen=1.
- Both lanes: address 0x300, same data.
- Trap data: snapshot with MPIE(bit7)=MIE(bit3), MIE=0, MPP[12:11]=2'b11.
- mret data: snapshot with MIE=MPIE, MPIE=1, MPP=2'b11.
- All other bits unchanged.
- Next: REDIR.

REDIR:
- redirect_valid=1, redirect_pc=target. Both held stable until redirect_ready.
- On the cycle with valid && ready: next state IDLE; redirect_valid drops the following cycle.
- Latency: trap entry is 3 cycles minimum from accept to redirect handshake; mret is 2 cycles.

busy:
- Combinationally high in the accept cycle and in every non-IDLE state.
- Low again in the first IDLE cycle after the handshake.

Boundary conditions:
- Events asserted while not IDLE are ignored. EXU must hold, because busy is high.
- Multiple flags in one accept cycle: priority applies, single sequence only.
- exu_valid=0 with flags high: no action.
- csr_wen is 0 in IDLE and REDIR.
- redirect_ready high outside REDIR: no effect.
- rst in any state: IDLE next cycle, outputs 0, no further CSR writes, pending redirect dropped.
- Back-to-back: a new event is acceptable in the first IDLE cycle after the handshake.

Test Plan:
1. ecall, pc=0x80000104, mtvec_i=0x80000201, mstatus_i=0x8, redirect_ready=1 -> expected response:
   - Cycle+1: wen, 0x341<=0x80000104, 0x342<=11.
   - Cycle+2: 0x300<=0x1880.
   - Cycle+3: redirect_valid, pc=0x80000200.
   - busy spans accept through cycle+3.
2. mret, mepc_i=0x80000108, mstatus_i=0x1880 -> expected response:
   - Cycle+1: 0x300<=0x1888.
   - Cycle+2: redirect to 0x80000108.
   - No 0x341/0x342 write.
3. illegal=ebreak=ecall=1 in one cycle -> mcause=2; exactly one sequence.
4. redirect_ready low for 5 cycles in REDIR -> redirect_valid and redirect_pc stable; csr_wen=0 throughout; exits one cycle after ready rises.
5. rst asserted during WR_EPC -> next cycle IDLE, csr_wen=0, redirect_valid=0, busy=0; no WR_STAT write.
6. ebreak while busy from an earlier ecall, then after the handshake -> first event ignored; second accepted with mcause=3.

Source files
------------

// File: rtl/ysyx_trap_ctrl_if.sv
// Bundle of EXU trap requests, CSR state snapshots, the CSR write port and the fetch redirect.
// The trap controller connects through the slave modport.
interface ysyx_trap_ctrl_if #(
  parameter int BIT_W = 32,
  parameter int R_W   = 12
);
  logic             exu_valid;
  logic             ecall;
  logic             ebreak;
  logic             illegal;
  logic             mret;
  logic [BIT_W-1:0] pc;
  logic [BIT_W-1:0] mtvec_i;
  logic [BIT_W-1:0] mepc_i;
  logic [BIT_W-1:0] mstatus_i;

  logic             csr_wen;
  logic [R_W-1:0]   csr_waddr;
  logic [BIT_W-1:0] csr_wdata;
  logic [R_W-1:0]   csr_waddr_add1;
  logic [BIT_W-1:0] csr_wdata_add1;

  logic             redirect_valid;
  logic [BIT_W-1:0] redirect_pc;
  logic             redirect_ready;
  logic             busy;

  modport master (
    output exu_valid, ecall, ebreak, illegal, mret, pc, mtvec_i, mepc_i, mstatus_i,
    output redirect_ready,
    input  csr_wen, csr_waddr, csr_wdata, csr_waddr_add1, csr_wdata_add1,
    input  redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  exu_valid, ecall, ebreak, illegal, mret, pc, mtvec_i, mepc_i, mstatus_i,
    input  redirect_ready,
    output csr_wen, csr_waddr, csr_wdata, csr_waddr_add1, csr_wdata_add1,
    output redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/ysyx_trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause and mstatus through the CSR port,
// then redirects fetch to mtvec (trap) or mepc (mret), stalling EXU throughout.
module ysyx_trap_ctrl #(
  parameter int BIT_W         = 32,
  parameter int R_W           = 12,
  parameter int CAUSE_ILLEGAL = 2,
  parameter int CAUSE_BREAK   = 3,
  parameter int CAUSE_ECALL_M = 11
) (
  input  logic clk,
  input  logic rst,
  ysyx_trap_ctrl_if.slave bus
);

  localparam logic [R_W-1:0] ADDR_MSTATUS = R_W'(12'h300);
  localparam logic [R_W-1:0] ADDR_MEPC    = R_W'(12'h341);
  localparam logic [R_W-1:0] ADDR_MCAUSE  = R_W'(12'h342);
  localparam logic [BIT_W-1:0] ALIGN_MASK = ~(BIT_W'(3));

  typedef enum logic [1:0] {IDLE, WR_EPC, WR_STAT, REDIR} state_t;

  state_t           state;
  logic [BIT_W-1:0] stat_snap;
  logic [BIT_W-1:0] target;

  logic             csr_wen_q;
  logic [R_W-1:0]   csr_waddr_q;
  logic [BIT_W-1:0] csr_wdata_q;
  logic [R_W-1:0]   csr_waddr_add1_q;
  logic [BIT_W-1:0] csr_wdata_add1_q;
  logic             redirect_valid_q;
  logic [BIT_W-1:0] redirect_pc_q;

  logic             accept;
  logic             is_trap;
  logic [BIT_W-1:0] cause_sel;

  function automatic logic [BIT_W-1:0] trap_status(input logic [BIT_W-1:0] s);
    logic [BIT_W-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [BIT_W-1:0] mret_status(input logic [BIT_W-1:0] s);
    logic [BIT_W-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Priority illegal > ebreak > ecall; mret only wins when no trap flag is set.
  always_comb begin
    is_trap   = bus.illegal | bus.ebreak | bus.ecall;
    accept    = (state == IDLE) && bus.exu_valid && (is_trap || bus.mret);
    cause_sel = '0;
    if (bus.illegal)     cause_sel = BIT_W'(CAUSE_ILLEGAL);
    else if (bus.ebreak) cause_sel = BIT_W'(CAUSE_BREAK);
    else if (bus.ecall)  cause_sel = BIT_W'(CAUSE_ECALL_M);
  end

  // Outputs are registered alongside the state, so each write lands in the cycle its state is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      stat_snap        <= '0;
      target           <= '0;
      csr_wen_q        <= 1'b0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      csr_waddr_add1_q <= '0;
      csr_wdata_add1_q <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            stat_snap <= bus.mstatus_i;
            csr_wen_q <= 1'b1;
            if (is_trap) begin
              state            <= WR_EPC;
              target           <= bus.mtvec_i & ALIGN_MASK;
              csr_waddr_q      <= ADDR_MEPC;
              csr_wdata_q      <= bus.pc & ALIGN_MASK;
              csr_waddr_add1_q <= ADDR_MCAUSE;
              csr_wdata_add1_q <= cause_sel;
            end else begin
              state            <= WR_STAT;
              target           <= bus.mepc_i;
              csr_waddr_q      <= ADDR_MSTATUS;
              csr_wdata_q      <= mret_status(bus.mstatus_i);
              csr_waddr_add1_q <= ADDR_MSTATUS;
              csr_wdata_add1_q <= mret_status(bus.mstatus_i);
            end
          end
        end
        WR_EPC: begin
          state            <= WR_STAT;
          csr_wen_q        <= 1'b1;
          csr_waddr_q      <= ADDR_MSTATUS;
          csr_wdata_q      <= trap_status(stat_snap);
          csr_waddr_add1_q <= ADDR_MSTATUS;
          csr_wdata_add1_q <= trap_status(stat_snap);
        end
        WR_STAT: begin
          state            <= REDIR;
          csr_wen_q        <= 1'b0;
          csr_waddr_q      <= '0;
          csr_wdata_q      <= '0;
          csr_waddr_add1_q <= '0;
          csr_wdata_add1_q <= '0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= target;
        end
        REDIR: begin
          if (bus.redirect_ready) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = accept || (state != IDLE);
  assign bus.csr_wen        = csr_wen_q;
  assign bus.csr_waddr      = csr_waddr_q;
  assign bus.csr_wdata      = csr_wdata_q;
  assign bus.csr_waddr_add1 = csr_waddr_add1_q;
  assign bus.csr_wdata_add1 = csr_wdata_add1_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule
